apb_master: RTL and testbench

// - Upstream requester for APB slaves (e.g. apb memory): converts a valid/ready request channel into
//   APB SETUP/ACCESS transfers and returns read data over a valid/ready response channel.
// - One outstanding transfer at a time; sits between a CPU/DMA-side bus adapter and the APB slave.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_master.sv | 166 ++++++++++++++++
 tb/tb_apb_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB master: the transfer-sequencing state encoding.
package apb_pkg;

  // Two-bit encoding keeps the state register minimal and the decode of
  // psel/penable/ready/valid a simple function of the current state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state_e;

endpackage

// File: rtl/apb_master.sv
// APB master: turns a valid/ready request into one APB SETUP/ACCESS transfer
// and returns the result on a valid/ready response channel. Only one transfer
// is in flight at a time.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that
// see no pready_i for TimeoutCycles cycles (response flagged with rsp_err_o).
module apb_master
  import apb_pkg::*;
#(
  parameter int AddrWidth     = 0,
  parameter int DataWidth     = 0,
  parameter int TimeoutCycles = 16
) (
  input  logic                                        clk_i,
  input  logic                                        arst_ni,
  input  logic                                        req_valid_i,
  output logic                                        req_ready_o,
  input  logic [((AddrWidth > 0) ? AddrWidth : 1)-1:0] req_addr_i,
  input  logic                                        req_write_i,
  input  logic [((DataWidth > 0) ? DataWidth : 1)-1:0] req_wdata_i,
  output logic                                        rsp_valid_o,
  input  logic                                        rsp_ready_i,
  output logic [((DataWidth > 0) ? DataWidth : 1)-1:0] rsp_rdata_o,
  output logic                                        rsp_err_o,
  output logic                                        psel_o,
  output logic                                        penable_o,
  output logic [((AddrWidth > 0) ? AddrWidth : 1)-1:0] paddr_o,
  output logic                                        pwrite_o,
  output logic [((DataWidth > 0) ? DataWidth : 1)-1:0] pwdata_o,
  input  logic [((DataWidth > 0) ? DataWidth : 1)-1:0] prdata_i,
  input  logic                                        pready_i
);

  // An unset width parameter falls back to one bit so the module still
  // elaborates on its own; real instances always override both widths.
  localparam int AW = (AddrWidth > 0) ? AddrWidth : 1;
  localparam int DW = (DataWidth > 0) ? DataWidth : 1;

  apb_master_state_e state_reg, state_next;

  logic [AW-1:0] paddr_reg;
  logic          pwrite_reg;
  logic [DW-1:0] pwdata_reg;
  logic [DW-1:0] rdata_reg;

  // Only a clean 1 completes the access; 0, X or Z from the slave all mean wait.
  logic access_done;
  logic timeout_hit;

  assign access_done = (state_reg == ACCESS) && (pready_i == 1'b1);

  // State register; reset drops any transfer in flight immediately.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake/APB control decode from the current state.
  always_comb begin
    state_next  = state_reg;
    req_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = SETUP;
      end
      SETUP: begin
        psel_o     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (access_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // APB address/direction/data are captured on acceptance and held until the
  // next request so the idle bus never toggles.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
    end else if ((state_reg == IDLE) && req_valid_i) begin
      paddr_reg  <= req_addr_i;
      pwrite_reg <= req_write_i;
      pwdata_reg <= req_wdata_i;
    end
  end

  // Response data: slave read data on completion of a read, zero for writes
  // and for aborted transfers; held through RESP until the next completion.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rdata_reg <= '0;
    end else if (access_done) begin
      rdata_reg <= pwrite_reg ? '0 : prdata_i;
    end else if (timeout_hit) begin
      rdata_reg <= '0;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] to_cnt_reg;
  logic            err_reg;

  // Abort on the TimeoutCycles-th ACCESS cycle without pready; a pready in
  // that same cycle still completes the transfer normally.
  assign timeout_hit = (state_reg == ACCESS) && !access_done && (to_cnt_reg == CntLast);

  // Counts ACCESS cycles spent waiting; cleared in SETUP so every transfer
  // starts with a full budget.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      to_cnt_reg <= '0;
    end else if (state_reg == SETUP) begin
      to_cnt_reg <= '0;
    end else if ((state_reg == ACCESS) && !access_done && !timeout_hit) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  // Error flag reflects how the last transfer ended.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      err_reg <= 1'b0;
    end else if (access_done) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  assign rsp_err_o = err_reg;
`else
  // Without the timeout feature ACCESS waits for the slave indefinitely.
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;

  // A zero timeout budget is meaningless even when the feature is compiled out.
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end
`endif

  assign paddr_o     = paddr_reg;
  assign pwrite_o    = pwrite_reg;
  assign pwdata_o    = pwdata_reg;
  assign rsp_rdata_o = rdata_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB memory slave model whose
// wait-state count is set per test. Timeout checks are compiled in only when
// APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic        req_write;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic [7:0]  paddr;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;

  int total;
  int bad;

  // slave model state
  int          wait_states;
  int          acc_cnt;
  logic [15:0] mem [0:255];

  apb_master #(
    .AddrWidth    (8),
    .DataWidth    (16),
    .TimeoutCycles(4)
  ) dut (
    .clk_i      (clk),
    .arst_ni    (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .psel_o     (psel),
    .penable_o  (penable),
    .paddr_o    (paddr),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .prdata_i   (prdata),
    .pready_i   (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // APB memory slave: ready after wait_states ACCESS cycles
  assign pready = psel && penable && (acc_cnt == wait_states);
  assign prdata = mem[paddr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[3] <= 16'hA5A5;
    end else if (psel && penable) begin
      if (pready) begin
        acc_cnt <= 0;
        if (pwrite) mem[paddr] <= pwdata;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer with rsp_ready held high; lat = edges from SETUP entry to rsp_valid
  task automatic run_xfer(input logic [7:0] a, input logic w, input logic [15:0] d,
                          output logic [15:0] rd, output logic er, output int lat);
    int guard;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    req_valid = 1'b0;
    lat   = 0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      tick();
      lat++;
      guard++;
    end
    check_val("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;

    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_write   = 1'b0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    wait_states = 0;

    // reset state
    repeat (2) tick();
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_psel", {31'd0, psel}, 32'd0);
    check_val("rst_penable", {31'd0, penable}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_paddr", {24'd0, paddr}, 32'd0);
    check_val("rst_pwdata", {16'd0, pwdata}, 32'd0);
    check_val("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    check_val("rst_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // read, zero-wait slave, cycle-exact
    req_addr  = 8'h03;
    req_write = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check_val("rd_setup_psel", {31'd0, psel}, 32'd1);
    check_val("rd_setup_penable", {31'd0, penable}, 32'd0);
    check_val("rd_setup_ready", {31'd0, req_ready}, 32'd0);
    check_val("rd_setup_paddr", {24'd0, paddr}, 32'h03);
    tick();
    check_val("rd_access_penable", {31'd0, penable}, 32'd1);
    check_val("rd_access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_val("rd_resp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("rd_resp_rdata", {16'd0, rsp_rdata}, 32'hA5A5);
    check_val("rd_resp_err", {31'd0, rsp_err}, 32'd0);
    check_val("rd_resp_psel", {31'd0, psel}, 32'd0);
    tick();
    check_val("rd_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rd_idle_ready", {31'd0, req_ready}, 32'd1);
    check_val("rd_idle_paddr_held", {24'd0, paddr}, 32'h03);

    // write with 2 wait states: bus stable over 3 ACCESS cycles
    wait_states = 2;
    req_addr  = 8'h07;
    req_write = 1'b1;
    req_wdata = 16'h1234;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("wr_acc%0d_psel", i), {31'd0, psel}, 32'd1);
      check_val($sformatf("wr_acc%0d_penable", i), {31'd0, penable}, 32'd1);
      check_val($sformatf("wr_acc%0d_paddr", i), {24'd0, paddr}, 32'h07);
      check_val($sformatf("wr_acc%0d_pwdata", i), {16'd0, pwdata}, 32'h1234);
      check_val($sformatf("wr_acc%0d_pwrite", i), {31'd0, pwrite}, 32'd1);
      check_val($sformatf("wr_acc%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check_val("wr_resp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("wr_resp_rdata", {16'd0, rsp_rdata}, 32'h0000);
    tick();

    // response backpressure with a competing request pending
    wait_states = 0;
    rsp_ready = 1'b0;
    req_addr  = 8'h07;
    req_write = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    req_addr  = 8'h09;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("bp%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      check_val($sformatf("bp%0d_rdata", i), {16'd0, rsp_rdata}, 32'h1234);
      check_val($sformatf("bp%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
      check_val($sformatf("bp%0d_psel", i), {31'd0, psel}, 32'd0);
      tick();
    end
    check_val("bp_paddr_held", {24'd0, paddr}, 32'h07);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check_val("bp_release_valid", {31'd0, rsp_valid}, 32'd0);

    // back-to-back write then read through the memory slave
    run_xfer(8'h02, 1'b1, 16'h0055, rd, er, lat);
    check_val("b2b_wr_rdata", {16'd0, rd}, 32'h0000);
    check_val("b2b_wr_lat", lat, 32'd2);
    run_xfer(8'h02, 1'b0, 16'h0000, rd, er, lat);
    check_val("b2b_rd_rdata", {16'd0, rd}, 32'h0055);
    check_val("b2b_rd_err", {31'd0, er}, 32'd0);
    check_val("b2b_rd_lat", lat, 32'd2);
    wait_states = 1;
    run_xfer(8'h07, 1'b0, 16'h0000, rd, er, lat);
    check_val("wait1_rdata", {16'd0, rd}, 32'h1234);
    check_val("wait1_lat", lat, 32'd3);

    // reset during ACCESS
    wait_states = 1000;
    req_addr  = 8'h03;
    req_write = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check_val("mid_access_penable", {31'd0, penable}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_psel", {31'd0, psel}, 32'd0);
    check_val("mid_rst_penable", {31'd0, penable}, 32'd0);
    check_val("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("mid_rst_paddr", {24'd0, paddr}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("post_rst%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
      check_val($sformatf("post_rst%0d_psel", i), {31'd0, psel}, 32'd0);
      tick();
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // slave never ready: abort after 4 ACCESS cycles
    wait_states = 1000;
    run_xfer(8'h03, 1'b0, 16'h0000, rd, er, lat);
    check_val("to_err", {31'd0, er}, 32'd1);
    check_val("to_rdata", {16'd0, rd}, 32'h0000);
    check_val("to_lat", lat, 32'd5);
    // pready arrives in the timeout cycle itself: completes without error
    wait_states = 3;
    run_xfer(8'h03, 1'b0, 16'h0000, rd, er, lat);
    check_val("to_edge_err", {31'd0, er}, 32'd0);
    check_val("to_edge_rdata", {16'd0, rd}, 32'hA5A5);
    check_val("to_edge_lat", lat, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
